product_accumulator: RTL and testbench

- Downstream consumer of sequential_multiplier: accumulates a programmed number of signed 64-bit products into a wider signed accumulator.
- Used for dot products and MAC-style sums over multiplier results.
- Products arrive over a valid/ready handshake; completion is flagged with a one-cycle done pulse.
- Single clock domain, same clock as the multiplier.

---
 rtl/product_accumulator_pkg.sv | 56 +++++
 rtl/acc_sat_adder.sv | 60 ++++++
 rtl/product_accumulator.sv | 110 +++++++++++
 tb/tb_product_accumulator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// product_accumulator_pkg
//
// Purpose : Shared types and constants for the product accumulator slice.
//           Holds the FSM state encoding, the default datapath widths and
//           the constant functions that build the signed clamp limits used
//           when saturation is compiled in (PRODUCT_ACCUMULATOR_SATURATE_EN).
//
// Contents: state_t        - IDLE / ACCUM / DONE state encoding
//           DEFAULT_PROD_W - signed product width from the multiplier
//           DEFAULT_ACC_W  - signed accumulator width (>= product width)
//           DEFAULT_CNT_W  - width of the product-count field
//           acc_max/acc_min- most positive / most negative value of a
//                            signed w-bit number, returned in 128 bits
// ---------------------------------------------------------------------------
package product_accumulator_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_PROD_W = 64;
    localparam int DEFAULT_ACC_W  = 72;
    localparam int DEFAULT_CNT_W  = 8;

    // Widest accumulator the limit functions can describe.
    localparam int LIMIT_W = 128;

    // Most positive w-bit signed value: 0 followed by (w-1) ones.
    function automatic logic [LIMIT_W-1:0] acc_max(input int w);
        logic [LIMIT_W-1:0] r;
        r = '0;
        for (int i = 0; i < LIMIT_W; i++) begin
            if (i < w - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Most negative w-bit signed value: 1 followed by (w-1) zeros; bits at
    // and above the sign position are set so the value is sign-correct.
    function automatic logic [LIMIT_W-1:0] acc_min(input int w);
        logic [LIMIT_W-1:0] r;
        r = '0;
        for (int i = 0; i < LIMIT_W; i++) begin
            if (i >= w - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_sat_adder.sv
// ---------------------------------------------------------------------------
// acc_sat_adder
//
// Purpose : Combinational signed adder for the accumulator. The product is
//           sign-extended to the accumulator width and added to the running
//           sum. Signed overflow is flagged when both addends share a sign
//           and the result sign differs.
//
//           Build option PRODUCT_ACCUMULATOR_SATURATE_EN:
//             defined   - on overflow the sum clamps to the most positive
//                         (positive overflow) or most negative (negative
//                         overflow) ACC_W value.
//             undefined - the sum wraps modulo 2^ACC_W.
//
// Ports   : i_acc  - current signed accumulator value (ACC_W)
//           i_prod - signed product (PROD_W)
//           o_sum  - next accumulator value (ACC_W)
//           o_ovf  - signed overflow of this addition
// ---------------------------------------------------------------------------
module acc_sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = DEFAULT_PROD_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [PROD_W-1:0] i_prod,
    output logic signed [ACC_W-1:0]  o_sum,
    output logic                     o_ovf
);

    logic signed [ACC_W-1:0] w_prodExt;
    logic signed [ACC_W-1:0] w_rawSum;

    // A signed size cast sign-extends, and also works when ACC_W == PROD_W.
    assign w_prodExt = ACC_W'(i_prod);
    assign w_rawSum  = i_acc + w_prodExt;

    assign o_ovf = (i_acc[ACC_W-1] == w_prodExt[ACC_W-1]) &&
                   (w_rawSum[ACC_W-1] != i_acc[ACC_W-1]);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam logic [LIMIT_W-1:0] MAX_FULL = acc_max(ACC_W);
    localparam logic [LIMIT_W-1:0] MIN_FULL = acc_min(ACC_W);
    localparam logic [ACC_W-1:0]   MAX_V    = MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]   MIN_V    = MIN_FULL[ACC_W-1:0];

    // On overflow both addends share a sign, so the operand sign tells the
    // direction: non-negative operands overflowed upward.
    always_comb begin
        o_sum = w_rawSum;
        if (o_ovf) begin
            o_sum = i_acc[ACC_W-1] ? MIN_V : MAX_V;
        end
    end
`else
    assign o_sum = w_rawSum;
`endif

endmodule

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Purpose : Accumulates a programmed number of signed products from the
//           sequential multiplier into a wider signed accumulator (dot
//           products, MAC sums). Products arrive over a valid/ready
//           handshake; a one-cycle done pulse marks the final sum.
//           Optional clamping on overflow is selected with the build macro
//           PRODUCT_ACCUMULATOR_SATURATE_EN (see acc_sat_adder).
//
// Ports   : clk        - system clock, rising edge
//           reset      - asynchronous active-high reset
//           start      - begin a run (sampled in IDLE only)
//           len        - number of products in the run (sampled with start)
//           prod_valid - prod carries a valid product
//           prod       - signed product (PROD_W)
//           prod_ready - block accepts prod this cycle
//           busy       - run in progress
//           done       - one-cycle pulse, acc_out holds the final sum
//           acc_out    - signed accumulator value (ACC_W)
//           overflow   - sticky signed-overflow flag for the current run
// ---------------------------------------------------------------------------
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = DEFAULT_PROD_W,
    parameter int ACC_W  = DEFAULT_ACC_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         len,
    input  logic                     prod_valid,
    input  logic signed [PROD_W-1:0] prod,
    output logic                     prod_ready,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     overflow
);

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;

    logic signed [ACC_W-1:0] w_sum;
    logic                    w_ovf;
    logic                    w_xfer;

    acc_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .i_acc  (r_acc),
        .i_prod (prod),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    // Status outputs decode straight from the state register so an async
    // reset drops them immediately, without waiting for a clock edge.
    assign prod_ready = (r_state == S_ACCUM);
    assign busy       = (r_state == S_ACCUM);
    assign done       = (r_state == S_DONE);
    assign acc_out    = r_acc;
    assign overflow   = r_ovf;

    assign w_xfer = prod_valid && prod_ready;

    // FSM, product counter and accumulator. A zero-length run skips ACCUM
    // and reports an empty (zero) sum via DONE on the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_count <= len;
                        r_state <= (len == '0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc   <= w_sum;
                        r_ovf   <= r_ovf | w_ovf;
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Purpose : Directed self-checking bench for product_accumulator. One
//           instance uses the default widths; a second one with a 64-bit
//           accumulator exercises signed overflow at the accumulator width.
//           Expected values for the overflow case depend on the build macro
//           PRODUCT_ACCUMULATOR_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

    logic        clk;
    logic        reset;

    // Default-width instance
    logic        start;
    logic [7:0]  len;
    logic        prodValid;
    logic [63:0] prod;
    logic        prodReady;
    logic        busy;
    logic        done;
    logic [71:0] accOut;
    logic        overflow;

    // 64-bit accumulator instance
    logic        start64;
    logic [7:0]  len64;
    logic        prodValid64;
    logic [63:0] prod64;
    logic        prodReady64;
    logic        busy64;
    logic        done64;
    logic [63:0] accOut64;
    logic        overflow64;

    int testCount = 0;
    int failCount = 0;

    product_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .prod_valid (prodValid),
        .prod       (prod),
        .prod_ready (prodReady),
        .busy       (busy),
        .done       (done),
        .acc_out    (accOut),
        .overflow   (overflow)
    );

    product_accumulator #(
        .PROD_W (64),
        .ACC_W  (64),
        .CNT_W  (8)
    ) dut64 (
        .clk        (clk),
        .reset      (reset),
        .start      (start64),
        .len        (len64),
        .prod_valid (prodValid64),
        .prod       (prod64),
        .prod_ready (prodReady64),
        .busy       (busy64),
        .done       (done64),
        .acc_out    (accOut64),
        .overflow   (overflow64)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the default instance's inputs (applied away from the edge).
    task automatic applyStimulus(input logic st, input logic [7:0] ln,
                                 input logic pv, input logic [63:0] pr);
        start     = st;
        len       = ln;
        prodValid = pv;
        prod      = pr;
    endtask

    task automatic checkOutput(input string tag, input logic [71:0] observed,
                               input logic [71:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);
        start64     = 1'b0;
        len64       = 8'd0;
        prodValid64 = 1'b0;
        prod64      = 64'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ---- Reset state
        checkOutput("rst_acc", accOut, 72'd0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ready", prodReady, 1'b0);
        checkOutput("rst_ovf", overflow, 1'b0);

        // ---- Test 1: len=3, -50 + 100 + 32 = 82 back-to-back
        applyStimulus(1'b1, 8'd3, 1'b0, 64'd0);
        tick();
        checkOutput("t1_busy", busy, 1'b1);
        checkOutput("t1_ready", prodReady, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b1, -64'sd50);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd100);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd32);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);
        checkOutput("t1_done", done, 1'b1);
        checkOutput("t1_busy_at_done", busy, 1'b0);
        checkOutput("t1_acc", accOut, 72'd82);
        checkOutput("t1_ovf", overflow, 1'b0);
        tick();
        checkOutput("t1_done_pulse", done, 1'b0);
        checkOutput("t1_acc_hold", accOut, 72'd82);

        // ---- Test 2: len=2, 36, gap of 3 cycles, 80 -> 116
        applyStimulus(1'b1, 8'd2, 1'b0, 64'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd36);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t2_gap_busy", busy, 1'b1);
            checkOutput("t2_gap_done", done, 1'b0);
        end
        checkOutput("t2_gap_acc", accOut, 72'd36);
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd80);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);
        checkOutput("t2_done", done, 1'b1);
        checkOutput("t2_acc", accOut, 72'd116);
        tick();
        checkOutput("t2_single_done", done, 1'b0);

        // ---- Test 3: len=0 -> done next cycle, sum 0, never ready
        applyStimulus(1'b1, 8'd0, 1'b1, 64'sd7);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);
        checkOutput("t3_done", done, 1'b1);
        checkOutput("t3_acc", accOut, 72'd0);
        checkOutput("t3_ready", prodReady, 1'b0);
        tick();
        checkOutput("t3_ready_after", prodReady, 1'b0);
        checkOutput("t3_done_after", done, 1'b0);

        // ---- Test 4: async reset mid-run, then a fresh run of one product
        applyStimulus(1'b1, 8'd4, 1'b0, 64'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, -64'sd45);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);
        checkOutput("t4_partial", accOut, -72'sd45);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t4_rst_acc", accOut, 72'd0);
        checkOutput("t4_rst_busy", busy, 1'b0);
        checkOutput("t4_rst_ready", prodReady, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1'b1, 8'd1, 1'b0, 64'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd10);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);
        checkOutput("t4_done", done, 1'b1);
        checkOutput("t4_acc", accOut, 72'd10);
        tick();

        // ---- Test 6: start ignored in ACCUM/DONE, prod_valid ignored in IDLE
        applyStimulus(1'b1, 8'd3, 1'b0, 64'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd5);
        tick();
        applyStimulus(1'b1, 8'd1, 1'b0, 64'd0);
        tick();
        checkOutput("t6_accum_busy", busy, 1'b1);
        checkOutput("t6_accum_acc", accOut, 72'd5);
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd7);
        tick();
        // Count must still be 1 here; a reload to 1 would have finished.
        checkOutput("t6_count_done", done, 1'b0);
        checkOutput("t6_count_busy", busy, 1'b1);
        applyStimulus(1'b1, 8'd5, 1'b1, 64'sd9);
        tick();
        checkOutput("t6_done", done, 1'b1);
        checkOutput("t6_acc", accOut, 72'd21);
        applyStimulus(1'b1, 8'd2, 1'b1, 64'sd50);
        tick();
        checkOutput("t6_start_in_done_busy", busy, 1'b0);
        checkOutput("t6_start_in_done_done", done, 1'b0);
        checkOutput("t6_start_in_done_acc", accOut, 72'd21);
        applyStimulus(1'b0, 8'd0, 1'b1, 64'sd99);
        tick();
        checkOutput("t6_idle_valid_acc", accOut, 72'd21);
        checkOutput("t6_idle_valid_busy", busy, 1'b0);
        checkOutput("t6_idle_valid_ready", prodReady, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 64'd0);

        // ---- Test 5: 64-bit accumulator, 2^62 + 2^62 overflows
        start64 = 1'b1;
        len64   = 8'd2;
        tick();
        start64     = 1'b0;
        len64       = 8'd0;
        prodValid64 = 1'b1;
        prod64      = 64'h4000_0000_0000_0000;
        tick();
        tick();
        prodValid64 = 1'b0;
        prod64      = 64'd0;
        checkOutput("t5_done", done64, 1'b1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        checkOutput("t5_acc_sat", accOut64, 72'h7FFF_FFFF_FFFF_FFFF);
`else
        checkOutput("t5_acc_wrap", accOut64, 72'h8000_0000_0000_0000);
`endif
        checkOutput("t5_ovf", overflow64, 1'b1);
        tick();
        checkOutput("t5_ovf_sticky", overflow64, 1'b1);
        // Next accepted start clears the flag.
        start64 = 1'b1;
        len64   = 8'd1;
        tick();
        start64     = 1'b0;
        len64       = 8'd0;
        checkOutput("t5_ovf_cleared", overflow64, 1'b0);
        prodValid64 = 1'b1;
        prod64      = 64'd1;
        tick();
        prodValid64 = 1'b0;
        checkOutput("t5_rerun_acc", accOut64, 72'd1);
        checkOutput("t5_rerun_ovf", overflow64, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
